alu_operand_stage: RTL and testbench

Parametrised, registered successor to the ALU operand enable gate. Accepts NCH operand channels of WIDTH bits each over a valid/ready handshake. Masks each channel by a global enable and a per-channel mask, then registers the result through a 2-entry skid buffer. Sits between the operand source and the ALU core, giving full-throughput pipelining with backpressure and a saturating count of zeroed transfers.

---
 rtl/alu_operand_stage.sv | 157 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//
// Registered operand stage that sits between the operand source and the ALU
// core. It accepts NCH operand channels of WIDTH bits each. Every channel is
// gated by the global enable and by its own mask bit. The gated word then
// passes through a 2-entry skid buffer, so the stage sustains one word per
// cycle and still absorbs backpressure from downstream.
//
// Handshake: a word moves across an interface on a rising edge only when that
// interface's valid and ready are both 1. Once valid is raised it stays high,
// and the data stays stable, until the transfer happens. ready may depend on
// this stage's state. It never depends on the same interface's valid.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   en         global operand enable, sampled when a word is accepted
//   ch_mask    per-channel enable [NCH-1:0], sampled when a word is accepted
//   in_valid   upstream word valid
//   in_ready   stage can accept (held low while rst is high)
//   in_data    packed operands; channel k sits at [k*WIDTH +: WIDTH]
//   out_valid  out_data holds a word
//   out_ready  downstream can take the word
//   out_data   gated, registered operands (the head entry)
//   zero_cnt   saturating count of accepted words that arrived with en=0
//   dbg_state  buffer occupancy: 0 = EMPTY, 1 = ONE, 2 = TWO
//   out_parity (only with OPERAND_PARITY_EN) even parity of each gated slice,
//              carried alongside its data word
//
// Optional feature macro: OPERAND_PARITY_EN

module alu_operand_stage #(
    parameter int WIDTH = 4,
    parameter int NCH   = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NCH-1:0]       ch_mask,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]     zero_cnt,
`ifdef OPERAND_PARITY_EN
    output logic [NCH-1:0]       out_parity,
`endif
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                 state;
    logic [NCH*WIDTH-1:0]   main_q;
    logic [NCH*WIDTH-1:0]   skid_q;
    logic [NCH*WIDTH-1:0]   gated;
    logic                   accept;

`ifdef OPERAND_PARITY_EN
    logic [NCH-1:0]         main_par_q;
    logic [NCH-1:0]         skid_par_q;
    logic [NCH-1:0]         gated_par;
`endif

    // Gating applies only to the word being accepted. Stored entries were
    // gated on entry and are never touched again.
    always_comb begin
        gated = '0;
        for (int k = 0; k < NCH; k++) begin
            gated[k*WIDTH +: WIDTH] = in_data[k*WIDTH +: WIDTH] & {WIDTH{en & ch_mask[k]}};
        end
    end

`ifdef OPERAND_PARITY_EN
    always_comb begin
        gated_par = '0;
        for (int k = 0; k < NCH; k++) begin
            gated_par[k] = ^gated[k*WIDTH +: WIDTH];
        end
    end
    assign out_parity = main_par_q;
`endif

    // in_ready is forced low during reset so that no word is accepted on the
    // same edge that clears the buffer.
    assign in_ready  = (state != TWO) & ~rst;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            zero_cnt <= '0;
`ifdef OPERAND_PARITY_EN
            main_par_q <= '0;
            skid_par_q <= '0;
`endif
        end else begin
            if (accept && !en && (zero_cnt != {CNT_W{1'b1}})) begin
                zero_cnt <= zero_cnt + 1'b1;
            end

            case (state)
                EMPTY: begin
                    if (accept) begin
                        state  <= ONE;
                        main_q <= gated;
`ifdef OPERAND_PARITY_EN
                        main_par_q <= gated_par;
`endif
                    end
                end
                ONE: begin
                    if (accept && out_ready) begin
                        // The old head leaves and the new word takes its place.
                        main_q <= gated;
`ifdef OPERAND_PARITY_EN
                        main_par_q <= gated_par;
`endif
                    end else if (accept) begin
                        state  <= TWO;
                        skid_q <= gated;
`ifdef OPERAND_PARITY_EN
                        skid_par_q <= gated_par;
`endif
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        state  <= ONE;
                        main_q <= skid_q;
`ifdef OPERAND_PARITY_EN
                        main_par_q <= skid_par_q;
`endif
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

    localparam int WIDTH = 4;
    localparam int NCH   = 2;
    localparam int CNT_W = 8;
    localparam int DW    = NCH * WIDTH;

    logic            clk;
    logic            rst;
    logic            en;
    logic [NCH-1:0]  ch_mask;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [CNT_W-1:0] zero_cnt;
    logic [1:0]      dbg_state;
`ifdef OPERAND_PARITY_EN
    logic [NCH-1:0]  out_parity;
`endif

    int checks;
    int errors;

    logic [DW-1:0] exp_q[$];

    alu_operand_stage #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ch_mask   (ch_mask),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .zero_cnt  (zero_cnt),
`ifdef OPERAND_PARITY_EN
        .out_parity(out_parity),
`endif
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge. Inputs change and outputs are sampled 1 time
    // unit after the edge, well away from the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; en = 1'b1; ch_mask = 2'b11;
        in_data = 8'hFF; out_ready = 1'b1;
        step();
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h exp 00", out_data); end
        checks++; if (zero_cnt !== 8'd0) begin errors++; $display("FAIL rst_zero_cnt got %0d exp 0", zero_cnt); end
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b exp 1", in_ready); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL post_rst_state got %0d exp 0", dbg_state); end
    endtask

    task automatic test_gate_off();
        en = 1'b0; ch_mask = 2'b11; in_data = 8'hCA; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gate_off_valid got %0b exp 1", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL gate_off_data got %h exp 00", out_data); end
        checks++; if (zero_cnt !== 8'd1) begin errors++; $display("FAIL gate_off_cnt got %0d exp 1", zero_cnt); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gate_off_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_gate_mask();
        en = 1'b1; ch_mask = 2'b11; in_data = 8'hE3; in_valid = 1'b1; out_ready = 1'b1;
        step();
        checks++; if (out_data !== 8'hE3) begin errors++; $display("FAIL mask11_data got %h exp e3", out_data); end
        checks++; if (zero_cnt !== 8'd1) begin errors++; $display("FAIL mask11_cnt got %0d exp 1", zero_cnt); end
`ifdef OPERAND_PARITY_EN
        checks++; if (out_parity !== 2'b10) begin errors++; $display("FAIL mask11_par got %b exp 10", out_parity); end
`endif
        ch_mask = 2'b01;
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== 8'h03) begin errors++; $display("FAIL mask01_data got %h exp 03", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mask01_valid got %0b exp 1", out_valid); end
`ifdef OPERAND_PARITY_EN
        checks++; if (out_parity !== 2'b00) begin errors++; $display("FAIL mask01_par got %b exp 00", out_parity); end
`endif
        ch_mask = 2'b11;
        step();
    endtask

    task automatic test_backpressure();
        en = 1'b1; ch_mask = 2'b11; out_ready = 1'b0;
        in_data = 8'hE3; in_valid = 1'b1;
        step();
        in_data = 8'h5A;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %0b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_two got %0b exp 0", in_ready); end
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL bp_state got %0d exp 2", dbg_state); end
        checks++; if (out_data !== 8'hE3) begin errors++; $display("FAIL bp_head got %h exp e3", out_data); end
        step();
        checks++; if (out_data !== 8'hE3 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got %h/%0b exp e3/1", out_data, out_valid); end
        out_ready = 1'b1;
        step();
        checks++; if (out_data !== 8'h5A || out_valid !== 1'b1) begin errors++; $display("FAIL bp_second got %h/%0b exp 5a/1", out_data, out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %0b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp;
        en = 1'b1; ch_mask = 2'b11; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'h10 + 8'(i);
            exp_q.push_back(in_data);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready i=%0d got %0b exp 1", i, in_ready); end
            step();
            exp = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1 || out_data !== exp) begin errors++; $display("FAIL stream_data i=%0d got %h/%0b exp %h/1", i, out_data, out_valid, exp); end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_saturation_reset();
        en = 1'b0; ch_mask = 2'b11; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
        for (int i = 0; i < 260; i++) begin
            step();
            if (i == 252) begin
                checks++; if (zero_cnt !== 8'd254) begin errors++; $display("FAIL sat_mid got %0d exp 254", zero_cnt); end
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (zero_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got %0d exp 255", zero_cnt); end

        en = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        step();
        in_data = 8'h88;
        step();
        in_valid = 1'b0;
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL mid_rst_full got %0d exp 2", dbg_state); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %0b exp 0", in_ready); end
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %0b exp 0", out_valid); end
        checks++; if (zero_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d exp 0", zero_cnt); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data got %h exp 00", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_ghost i=%0d got %0b/%h exp 0", i, out_valid, out_data); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; en = 1'b0; ch_mask = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_gate_off();
        test_gate_mask();
        test_backpressure();
        test_back_to_back();
        test_saturation_reset();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expected got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
